// File: rtl/param_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : param_decoder_seq
// Purpose  : Registered one-hot decoder with direct-decode and auto-scan modes.
//            Optional macro PARAM_DECODER_ACTIVE_LOW_EN makes out one-cold.
// Revision : 1.0
// ============================================================================
module param_decoder_seq #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [2**SEL_W-1:0]   out,
    output logic                  out_valid,
    output logic                  scan_wrap
);

    localparam int c_N = 2**SEL_W;
`ifdef PARAM_DECODER_ACTIVE_LOW_EN
    localparam logic [c_N-1:0] c_OUT_MASK = '1;
`else
    localparam logic [c_N-1:0] c_OUT_MASK = '0;
`endif
    localparam logic [SEL_W-1:0] c_IDX_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t               r_state, w_state_next;
    logic [SEL_W-1:0]     r_idx, w_idx_next;
    logic [DWELL_W-1:0]   r_cnt, w_cnt_next;
    logic [c_N-1:0]       r_out, w_out_next;
    logic                 r_valid, w_valid_next;
    logic                 r_wrap, w_wrap_next;
    logic                 r_ready;
    logic                 w_accept;

    function automatic logic [c_N-1:0] f_onehot(input logic [SEL_W-1:0] i);
        logic [c_N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // r_ready marks the DIRECT state; live en/mode qualify it so a dropped
    // enable or a pending mode change never advertises readiness.
    assign in_ready  = r_ready & en & ~mode;
    assign w_accept  = in_valid & in_ready;
    assign out       = r_out;
    assign out_valid = r_valid;
    assign scan_wrap = r_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_out   <= c_OUT_MASK;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_out   <= w_out_next;
            r_valid <= w_valid_next;
            r_wrap  <= w_wrap_next;
            r_ready <= (w_state_next == S_DIRECT);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_out_next   = r_out;
        w_valid_next = r_valid;
        w_wrap_next  = 1'b0;

        if (!en) begin
            w_state_next = S_IDLE;
            w_idx_next   = '0;
            w_cnt_next   = '0;
            w_out_next   = c_OUT_MASK;
            w_valid_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_out_next   = c_OUT_MASK;
                    w_valid_next = 1'b0;
                    if (mode) begin
                        w_state_next = S_SCAN;
                        w_idx_next   = '0;
                        w_cnt_next   = dwell;
                        w_out_next   = f_onehot('0) ^ c_OUT_MASK;
                        w_valid_next = 1'b1;
                    end else begin
                        w_state_next = S_DIRECT;
                    end
                end
                S_DIRECT: begin
                    if (mode) begin
                        w_state_next = S_IDLE;
                        w_out_next   = c_OUT_MASK;
                        w_valid_next = 1'b0;
                    end else if (w_accept) begin
                        w_out_next   = f_onehot(sel) ^ c_OUT_MASK;
                        w_valid_next = 1'b1;
                    end
                end
                S_SCAN: begin
                    if (!mode) begin
                        w_state_next = S_IDLE;
                        w_idx_next   = '0;
                        w_cnt_next   = '0;
                        w_out_next   = c_OUT_MASK;
                        w_valid_next = 1'b0;
                    end else if (r_cnt == '0) begin
                        // dwell is only sampled here and on entry
                        w_idx_next   = r_idx + 1'b1;
                        w_cnt_next   = dwell;
                        w_out_next   = f_onehot(r_idx + 1'b1) ^ c_OUT_MASK;
                        w_valid_next = 1'b1;
                        w_wrap_next  = (r_idx == c_IDX_MAX);
                    end else begin
                        w_cnt_next   = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_idx_next   = '0;
                    w_cnt_next   = '0;
                    w_out_next   = c_OUT_MASK;
                    w_valid_next = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_decoder_seq
// Purpose  : Directed scoreboard bench for param_decoder_seq (SEL_W=2).
// Revision : 1.0
// ============================================================================
module tb_param_decoder_seq;

`ifdef PARAM_DECODER_ACTIVE_LOW_EN
    localparam logic [3:0] c_MASK = 4'b1111;
`else
    localparam logic [3:0] c_MASK = 4'b0000;
`endif

    typedef struct packed {
        logic [3:0] out;
        logic       valid;
        logic       wrap;
        logic       ready;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, en, mode, in_valid;
    logic       in_ready, out_valid, scan_wrap;
    logic [1:0] sel;
    logic [3:0] dwell;
    logic [3:0] out;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    param_decoder_seq #(.SEL_W(2), .DWELL_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .dwell     (dwell),
        .out       (out),
        .out_valid (out_valid),
        .scan_wrap (scan_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        assert (act === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, act, exp);
    endtask

    // Drive one cycle; expected values describe the outputs after the edge.
    task automatic cyc(input string tag, input logic r, input logic e, input logic m,
                       input logic iv, input logic [1:0] s, input logic [3:0] dw,
                       input logic [3:0] eo, input logic ev, input logic ew, input logic er);
        exp_t x, got;
        reset = r; en = e; mode = m; in_valid = iv; sel = s; dwell = dw;
        x.out = eo ^ c_MASK; x.valid = ev; x.wrap = ew; x.ready = er;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({tag, ".out"},       out,                 got.out);
        check({tag, ".out_valid"}, {3'b0, out_valid},   {3'b0, got.valid});
        check({tag, ".scan_wrap"}, {3'b0, scan_wrap},   {3'b0, got.wrap});
        check({tag, ".in_ready"},  {3'b0, in_ready},    {3'b0, got.ready});
        check({tag, ".onehot"},    {3'b0, ($countones(out ^ c_MASK) <= 1)}, 4'd1);
    endtask

    initial begin
        logic [3:0] eo;
        reset = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b1; sel = 2'd2; dwell = 4'd1;

        cyc("rst0", 1, 1, 1, 1, 2'd2, 4'd1, 4'b0000, 0, 0, 0);
        cyc("rst1", 1, 1, 0, 1, 2'd2, 4'd1, 4'b0000, 0, 0, 0);
        cyc("enter_direct", 0, 1, 0, 0, 2'd2, 4'd1, 4'b0000, 0, 0, 1);
        cyc("dir_sel2", 0, 1, 0, 1, 2'd2, 4'd1, 4'b0100, 1, 0, 1);
        cyc("dir_sel0", 0, 1, 0, 1, 2'd0, 4'd1, 4'b0001, 1, 0, 1);
        cyc("dir_sel3", 0, 1, 0, 1, 2'd3, 4'd1, 4'b1000, 1, 0, 1);
        cyc("dir_sel1", 0, 1, 0, 1, 2'd1, 4'd1, 4'b0010, 1, 0, 1);
        cyc("dir_hold", 0, 1, 0, 0, 2'd3, 4'd1, 4'b0010, 1, 0, 1);
        cyc("dir_sel2b", 0, 1, 0, 1, 2'd2, 4'd1, 4'b0100, 1, 0, 1);
        cyc("d2s_idle", 0, 1, 1, 0, 2'd0, 4'd1, 4'b0000, 0, 0, 0);
        cyc("scan_k0", 0, 1, 1, 0, 2'd0, 4'd1, 4'b0001, 1, 0, 0);

        // dwell=1 scan; dwell is perturbed on edges that must ignore it
        for (int k = 1; k <= 10; k++) begin
            eo = 4'b0001 << ((k / 2) % 4);
            cyc($sformatf("scan_k%0d", k), 0, 1, 1, 0, 2'd0,
                (k % 2 == 1) ? 4'd7 : 4'd1, eo, 1, (k == 8), 0);
        end

        cyc("en_drop", 0, 0, 1, 1, 2'd0, 4'd0, 4'b0000, 0, 0, 0);
        cyc("en_back_idle", 0, 1, 1, 0, 2'd0, 4'd0, 4'b0001, 1, 0, 0);
        cyc("d0_1", 0, 1, 1, 0, 2'd0, 4'd0, 4'b0010, 1, 0, 0);
        cyc("d0_2", 0, 1, 1, 0, 2'd0, 4'd0, 4'b0100, 1, 0, 0);
        cyc("d0_3", 0, 1, 1, 0, 2'd0, 4'd0, 4'b1000, 1, 0, 0);
        cyc("d0_wrap", 0, 1, 1, 0, 2'd0, 4'd0, 4'b0001, 1, 1, 0);
        cyc("d0_5", 0, 1, 1, 0, 2'd0, 4'd0, 4'b0010, 1, 0, 0);
        cyc("d0_6", 0, 1, 1, 0, 2'd0, 4'd0, 4'b0100, 1, 0, 0);
        cyc("d0_7", 0, 1, 1, 0, 2'd0, 4'd0, 4'b1000, 1, 0, 0);
        cyc("rst_mid_scan", 1, 1, 1, 1, 2'd1, 4'd0, 4'b0000, 0, 0, 0);
        cyc("post_rst", 0, 1, 0, 0, 2'd1, 4'd0, 4'b0000, 0, 0, 1);
        cyc("post_rst_sel1", 0, 1, 0, 1, 2'd1, 4'd0, 4'b0010, 1, 0, 1);

        cyc("d2s_idle_b", 0, 1, 1, 0, 2'd0, 4'd0, 4'b0000, 0, 0, 0);
        cyc("scan_b", 0, 1, 1, 0, 2'd0, 4'd0, 4'b0001, 1, 0, 0);
        cyc("s2d_idle", 0, 1, 0, 1, 2'd3, 4'd0, 4'b0000, 0, 0, 0);
        cyc("s2d_enter", 0, 1, 0, 1, 2'd3, 4'd0, 4'b0000, 0, 0, 1);
        cyc("s2d_sel3", 0, 1, 0, 1, 2'd3, 4'd0, 4'b1000, 1, 0, 1);
        cyc("en_prio", 0, 0, 0, 1, 2'd1, 4'd0, 4'b0000, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_decoder_seq.md
PARAM_DECODER_SEQ -- requirements
Module: param_decoder_seq

Interface
REQ-001 SHALL provide parameter SEL_W, default 2: select width; output width is 2**SEL_W, legal range 1..6.
REQ-002 SHALL provide parameter DWELL_W, default 4: width of the scan dwell count.
REQ-003 SHALL use one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 en  input  1  global enable; low forces outputs inactive.
REQ-007 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-008 in_valid  input  1  sel is valid this cycle (direct mode).
REQ-009 in_ready  output  1  block accepts sel this cycle.
REQ-010 sel  input  SEL_W  index to decode.
REQ-011 dwell  input  DWELL_W  scan hold length; each line is held dwell+1 cycles.
REQ-012 out  output  2**SEL_W  registered one-hot decode.
REQ-013 out_valid  output  1  out holds an active decode.
REQ-014 scan_wrap  output  1  one-cycle pulse when the scan wraps from the top line to line 0.

Function
REQ-015 SHALL implement FSM states IDLE, DIRECT and SCAN; all outputs registered.
REQ-016 IDLE: out=0, out_valid=0; en=1 and mode=0 -> DIRECT; en=1 and mode=1 -> SCAN with index 0 and the dwell counter loaded from dwell.
REQ-017 in_ready SHALL be 1 only in IDLE or DIRECT with en=1 and mode=0; it SHALL be 0 in SCAN.
REQ-018 DIRECT: on in_valid and in_ready, out SHALL equal one-hot(sel) and out_valid=1 on the next edge (latency 1); with no accept, out and out_valid hold.
REQ-019 Back-to-back accepts SHALL update out every cycle with no bubble.
REQ-020 SCAN: out=one-hot(idx), out_valid=1; each idx SHALL be held dwell+1 cycles, then idx increments.
REQ-021 dwell SHALL be sampled on SCAN entry and at each idx advance; changes mid-hold SHALL be ignored.
REQ-022 Wrap: when idx=2**SEL_W-1 expires, idx SHALL become 0, and scan_wrap SHALL be 1 during the first cycle in which out shows line 0 after the wrap; scan_wrap SHALL be 0 otherwise.
REQ-023 dwell=0 SHALL advance idx every cycle; SEL_W=1 SHALL alternate lines 0 and 1.
REQ-024 en=0 in any state SHALL give state IDLE, out=0, out_valid=0, scan_wrap=0 on the next edge; en=0 takes priority over mode and in_valid.
REQ-025 A mode change DIRECT<->SCAN SHALL pass through IDLE for exactly one cycle (out=0), then enter the new mode.
REQ-026 out SHALL never have more than one bit active in any cycle.

Reset
REQ-027 reset=1 SHALL on the next edge give state IDLE, idx=0, dwell counter 0, out=0, out_valid=0, scan_wrap=0, in_ready=0, and override all other inputs.
REQ-028 Reset asserted mid-scan or mid-direct SHALL abort immediately; no partial pulse SHALL follow deassertion.
REQ-029 After deassertion, the first state transition SHALL occur no earlier than the second edge.

Configuration
REQ-030 Macro PARAM_DECODER_ACTIVE_LOW_EN: when defined, out SHALL be one-cold (all bits inverted, including the reset value, all-ones); when undefined, out is one-hot with reset value 0. All other outputs are unaffected.

Verification
REQ-031 SEL_W=2, en=1, mode=0, in_valid=1, sel=2'b10 -> next cycle out=4'b0100, out_valid=1.
REQ-032 SEL_W=2, mode=1, dwell=1 -> out sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001; scan_wrap=1 only on the cycle of the second visit's first 0001.
REQ-033 Mid-scan, en dropped to 0 -> next cycle out=0, out_valid=0, in_ready=0; en restored -> scan restarts at 0001.
REQ-034 Reset asserted while out=1000 in SCAN -> next cycle all outputs 0; after release, sel=2'b01 accept -> out=0010.
REQ-035 DIRECT with out=0100, mode set to 1 -> one cycle with out=0, then 0001 in SCAN.
REQ-036 With PARAM_DECODER_ACTIVE_LOW_EN defined, sel=2'b00 accept -> out=4'b1110; under reset, out=4'b1111.
